// File: rtl/truth_table_reader.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_reader
//  Description : Walks a 3-input combinational function through all eight
//                input combinations, holding each for SETTLE cycles before
//                sampling its output. Assembles the eight samples into a
//                captured truth table, reports its popcount, and compares it
//                against a reference table.
//
//  Parameters  : SETTLE     - cycles each input pattern is held before sampling
//                             (1..15)
//  Ports       : clk        - single clock, rising edge
//                reset_n    - asynchronous active-low reset
//                start      - capture request, honoured only when idle
//                dut_y      - output of the function under read
//                expected   - reference table, bit i = expected y for index i
//                dut_a/b/c  - driven function inputs, {a,b,c} = index (a MSB)
//                busy       - capture in progress
//                done       - one-cycle pulse at capture completion
//                cap_table  - captured table, bit i = sampled y for index i
//                             (the name "table" is a reserved word)
//                ones       - popcount of cap_table
//                match      - cap_table == expected
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_reader #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       dut_y,
    input  logic [7:0] expected,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic [7:0] cap_table,
    output logic [3:0] ones,
    output logic       match
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [3:0] c_SETTLE = 4'(SETTLE);

    logic [1:0] r_state;
    logic [2:0] r_index;
    logic [3:0] r_cnt;
    logic [7:0] r_table;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic [3:0] w_ones;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_index <= 3'd0;
            r_cnt   <= 4'd0;
            r_table <= 8'd0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_WAIT;
                        r_index <= 3'd0;
                        r_cnt   <= c_SETTLE;
                        r_table <= 8'd0;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                c_WAIT: begin
                    // The counter is loaded with SETTLE on entry, so leaving
                    // when it reaches 1 keeps WAIT for exactly SETTLE cycles.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_SAMPLE;
                    end
                end
                c_SAMPLE: begin
                    r_table[r_index] <= dut_y;
                    if (r_index == 3'd7) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_abc   <= 3'd0;
                    end else begin
                        r_state <= c_WAIT;
                        r_index <= r_index + 3'd1;
                        r_abc   <= r_index + 3'd1;
                        r_cnt   <= c_SETTLE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'd0, r_table[i]};
        end
    end

    assign dut_a     = r_abc[2];
    assign dut_b     = r_abc[1];
    assign dut_c     = r_abc[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign cap_table = r_table;
    assign ones      = w_ones;
    assign match     = (r_table == expected);

endmodule
`default_nettype wire

// File: doc/truth_table_reader.md
TRUTH_TABLE_READER -- requirements
Module: truth_table_reader

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles inputs are held stable before y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to capture a new truth table; accepted only in IDLE.
REQ-005 dut_y  input  1  output of the 3-input combinational function under read.
REQ-006 expected  input  8  reference truth table; bit i = expected y for {a,b,c}=i.
REQ-007 dut_a, dut_b, dut_c  output  1 each  driven function inputs; {dut_a,dut_b,dut_c} = current index, a is MSB.
REQ-008 busy  output  1  high while a capture is in progress.
REQ-009 done  output  1  one-cycle pulse when a capture completes.
REQ-010 table  output  8  captured truth table; bit i = sampled dut_y for index i.
REQ-011 ones  output  4  popcount of table, range 0..8.
REQ-012 match  output  1  high when table == expected; combinational compare of the registered table.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, SAMPLE, DONE.
REQ-014 IDLE: busy=0; {a,b,c}=000; start=1 at a rising edge -> WAIT, index=0, settle counter=SETTLE, table cleared to 0.
REQ-015 WAIT: {a,b,c}=index; counter decrements each cycle; the state is held for exactly SETTLE cycles, then -> SAMPLE.
REQ-016 SAMPLE (1 cycle): table[index] <= dut_y; if index==7 -> DONE, else index+1, counter reloads SETTLE -> WAIT.
REQ-017 DONE (1 cycle): done=1, busy=0, {a,b,c}=000 -> IDLE.
REQ-018 busy SHALL be 1 in WAIT and SAMPLE only.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+8*(SETTLE+1); SETTLE=1 gives 16 cycles.
REQ-020 start in WAIT, SAMPLE, or DONE SHALL be ignored; no restart and no queueing.
REQ-021 start held high continuously SHALL begin a new capture on the first edge in IDLE after DONE; back-to-back captures are separated by exactly one IDLE cycle.
REQ-022 table, ones, and match SHALL hold their values after DONE until the next accepted start clears table.
REQ-023 ones SHALL be recomputed from the registered table; no overflow is possible (4 bits covers 8).
REQ-024 During a capture, table bits not yet sampled SHALL read 0.
REQ-025 The index counter SHALL not wrap; index 7 always terminates in DONE.

Reset
REQ-026 reset_n=0 SHALL immediately and asynchronously force IDLE, index=0, counter=0, table=0, dut_a/b/c=0, busy=0, done=0.
REQ-027 While in reset, ones=0 and match=(expected==8'h00).
REQ-028 Reset asserted mid-capture SHALL abort the capture with no done pulse; the partial table is discarded.
REQ-029 After reset_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-030 Function y=~a&~b&~c | a&~b&~c | a&~b&c, SETTLE=1, expected=8'h31, pulse start -> done 16 cycles after acceptance, table=8'h31, ones=4'd3, match=1.
REQ-031 dut_y tied 1, expected=8'h00 -> table=8'hFF, ones=4'd8, match=0; dut inputs step 000..111 with each value held SETTLE+1 cycles.
REQ-032 SETTLE=3, y=dut_a -> table=8'hF0, done 32 cycles after acceptance; start pulses at cycles 5 and 20 of the capture are ignored.
REQ-033 start held high through two captures with y=~dut_c -> two done pulses 18 cycles apart (SETTLE=1); table=8'h55 both times.
REQ-034 reset_n pulsed low at cycle 7 of a capture -> all outputs 0 asynchronously, no done; the next start produces a full correct table.
REQ-035 reset_n deasserted with start already high -> capture begins on the first edge; busy=1 in the following cycle.
